// File: rtl/req_arbiter.sv
// req_arbiter: round-robin arbiter with bounded grant tenures.
//
// Each tenure grants one client for 1..HOLD cycles. A tenure ends early when
// that client drops its request. Every tenure is followed by exactly one
// RELEASE cycle with grant=0. The search pointer then moves to the client after
// the one just served, so continuous requesters are served in ascending order.
//
// Ports:
//   clock        in   rising-edge clock for all state
//   reset_n      in   asynchronous active-low reset
//   req          in   [N-1:0] level request vector, bit i from client i
//   grant        out  [N-1:0] one-hot grant, or all zeros
//   grant_valid  out  high exactly when grant is non-zero
//   grant_id     out  [$clog2(N)-1:0] index of the granted client; holds its
//                     last value when grant_valid is low
//   grant_count  out  [15:0] number of tenures started, saturating at 16'hFFFF
//
// All outputs are registered.

module req_arbiter #(
  parameter int N    = 8,
  parameter int HOLD = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [15:0]          grant_count
);

  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [N-1:0]     grant_reg, grant_next;
  logic             valid_reg, valid_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic [15:0]      grant_count_reg, grant_count_next;

  // Round-robin search: find the first set request at or above ptr_reg,
  // wrapping from N-1 back to 0.
  logic             arb_found;
  logic [IDW-1:0]   arb_id;

  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_reg) + off;
      if (idx >= N) idx = idx - N;
      if (!arb_found && req[IDW'(idx)]) begin
        arb_found = 1'b1;
        arb_id    = IDW'(idx);
      end
    end
  end

  // The tenure ends when the granted client drops its request or when the
  // hold budget is used up. Only the granted client's bit is looked at, so
  // activity on the other request lines cannot disturb the tenure.
  logic tenure_end;
  assign tenure_end = !req[id_reg] || (cnt_reg == 8'(HOLD - 1));

  // State register. The outputs are registered here as well.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      cnt_reg         <= '0;
      grant_reg       <= '0;
      valid_reg       <= 1'b0;
      id_reg          <= '0;
      grant_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      cnt_reg         <= cnt_next;
      grant_reg       <= grant_next;
      valid_reg       <= valid_next;
      id_reg          <= id_next;
      grant_count_reg <= grant_count_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, RELEASE: state_next = arb_found ? GRANT : IDLE;
      GRANT:         state_next = tenure_end ? RELEASE : GRANT;
      default:       state_next = IDLE;
    endcase
  end

  // Output and datapath logic. This computes the register values that go with
  // each transition.
  always_comb begin
    ptr_next         = ptr_reg;
    cnt_next         = cnt_reg;
    grant_next       = grant_reg;
    valid_next       = valid_reg;
    id_next          = id_reg;
    grant_count_next = grant_count_reg;
    case (state_reg)
      GRANT: begin
        if (tenure_end) begin
          grant_next = '0;
          valid_next = 1'b0;
          ptr_next   = (id_reg == IDW'(N - 1)) ? '0 : id_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        if (arb_found) begin
          grant_next = {{(N-1){1'b0}}, 1'b1} << arb_id;
          valid_next = 1'b1;
          id_next    = arb_id;
          cnt_next   = '0;
          if (grant_count_reg != 16'hFFFF)
            grant_count_next = grant_count_reg + 16'd1;
        end else begin
          grant_next = '0;
          valid_next = 1'b0;
        end
      end
    endcase
  end

  assign grant       = grant_reg;
  assign grant_valid = valid_reg;
  assign grant_id    = id_reg;
  assign grant_count = grant_count_reg;

endmodule

// File: tb/tb_req_arbiter.sv
// Testbench for req_arbiter.
// It drives the main instance with N=8 and HOLD=4, and a second instance with
// HOLD=1 whose requests are always all ones. Expected outputs are queued when
// the stimulus is applied. They are popped and compared one time unit after
// the clock edge that produces them.

module tb_req_arbiter;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  req     = 8'h00;
  logic [7:0]  req1    = 8'hFF;

  logic [7:0]  grant;
  logic        grant_valid;
  logic [2:0]  grant_id;
  logic [15:0] grant_count;

  logic [7:0]  g1;
  logic        g1_valid;
  logic [2:0]  g1_id;
  logic [15:0] g1_count;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  typedef struct {
    logic [7:0]  req;
    logic [7:0]  grant;
    logic [2:0]  id;
    logic [15:0] count;
  } vec_t;

  vec_t exp_q[$];
  vec_t tab_a[11];
  vec_t tab_c[10];

  req_arbiter #(.N(8), .HOLD(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .grant(grant), .grant_valid(grant_valid),
    .grant_id(grant_id), .grant_count(grant_count)
  );

  req_arbiter #(.N(8), .HOLD(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req1),
    .grant(g1), .grant_valid(g1_valid),
    .grant_id(g1_id), .grant_count(g1_count)
  );

  always #5 clock = ~clock;

  // Checked on every cycle: grant is one-hot or zero, and grant_valid is the
  // OR of grant.
  always @(negedge clock) begin
    if (inv_en) begin
      checks += 4;
      if (!$onehot0(grant)) begin
        errors++; $display("FAIL onehot grant=%h", grant);
      end
      if (grant_valid !== (|grant)) begin
        errors++; $display("FAIL valid_or got %b want %b", grant_valid, |grant);
      end
      if (!$onehot0(g1)) begin
        errors++; $display("FAIL onehot_hold1 grant=%h", g1);
      end
      if (g1_valid !== (|g1)) begin
        errors++; $display("FAIL valid_or_hold1 got %b want %b", g1_valid, |g1);
      end
    end
  end

  task automatic check_out(input string tag, input logic [7:0] eg,
                           input logic [2:0] eid, input logic [15:0] ec);
    checks += 4;
    if (grant !== eg) begin
      errors++; $display("FAIL %s grant got %h want %h", tag, grant, eg);
    end
    if (grant_valid !== (|eg)) begin
      errors++; $display("FAIL %s grant_valid got %b want %b", tag, grant_valid, |eg);
    end
    if (grant_id !== eid) begin
      errors++; $display("FAIL %s grant_id got %0d want %0d", tag, grant_id, eid);
    end
    if (grant_count !== ec) begin
      errors++; $display("FAIL %s grant_count got %h want %h", tag, grant_count, ec);
    end
    $display("txn %-10s req=%h grant=%h valid=%b id=%0d count=%h",
             tag, req, grant, grant_valid, grant_id, grant_count);
  endtask

  // Drive one request vector, queue its expected result, and wait for the
  // edge that produces it. Then pop the result and compare it.
  task automatic step(input string tag, input logic [7:0] r, input logic [7:0] eg,
                      input logic [2:0] eid, input logic [15:0] ec);
    vec_t v;
    v.req = r; v.grant = eg; v.id = eid; v.count = ec;
    req = r;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    v = exp_q.pop_front();
    check_out(tag, v.grant, v.id, v.count);
  endtask

  // Reset with requests present. The outputs must be clear at once, and must
  // stay clear across a clock edge while reset is held.
  task automatic do_reset();
    req = 8'hFF;
    reset_n = 1'b0;
    #1;
    check_out("reset", 8'h00, 3'd0, 16'd0);
    @(posedge clock);
    #1;
    check_out("reset_clk", 8'h00, 3'd0, 16'd0);
    checks += 2;
    if (g1 !== 8'h00) begin
      errors++; $display("FAIL reset_hold1 grant got %h want 00", g1);
    end
    if (g1_count !== 16'd0) begin
      errors++; $display("FAIL reset_hold1 count got %h want 0000", g1_count);
    end
    @(negedge clock);
    req = 8'h00;
    reset_n = 1'b1;
    inv_en = 1'b1;
  endtask

  initial begin
    // A single persistent requester (client 3). It gets 4-cycle tenures, each
    // followed by one zero cycle.
    tab_a = '{
      '{8'h08, 8'h08, 3'd3, 16'd1}, '{8'h08, 8'h08, 3'd3, 16'd1},
      '{8'h08, 8'h08, 3'd3, 16'd1}, '{8'h08, 8'h08, 3'd3, 16'd1},
      '{8'h08, 8'h00, 3'd3, 16'd1},
      '{8'h08, 8'h08, 3'd3, 16'd2}, '{8'h08, 8'h08, 3'd3, 16'd2},
      '{8'h08, 8'h08, 3'd3, 16'd2}, '{8'h08, 8'h08, 3'd3, 16'd2},
      '{8'h08, 8'h00, 3'd3, 16'd2},
      '{8'h08, 8'h08, 3'd3, 16'd3}
    };
    // Early drop by client 2 leaves ptr at 3, so client 0 is found only after
    // wrapping. During that tenure the other bits toggle or go X with no
    // effect. The next tenure starts its search from 1.
    tab_c = '{
      '{8'h04, 8'h04, 3'd2, 16'd1}, '{8'h04, 8'h04, 3'd2, 16'd1},
      '{8'h00, 8'h00, 3'd2, 16'd1}, '{8'h00, 8'h00, 3'd2, 16'd1},
      '{8'h05, 8'h01, 3'd0, 16'd2}, '{8'h05, 8'h01, 3'd0, 16'd2},
      '{8'hFF, 8'h01, 3'd0, 16'd2}, '{8'bxxxx_xxx1, 8'h01, 3'd0, 16'd2},
      '{8'h05, 8'h00, 3'd0, 16'd2}, '{8'h05, 8'h04, 3'd2, 16'd3}
    };

    #1;
    do_reset();
    foreach (tab_a[i]) step("persist", tab_a[i].req, tab_a[i].grant, tab_a[i].id, tab_a[i].count);

    // All clients requesting. The main instance rotates 01..80 and wraps,
    // with 4-cycle tenures. The HOLD=1 instance alternates grant and zero.
    do_reset();
    for (int j = 0; j < 42; j++) begin
      int t, p, t1;
      logic [7:0] eg, eg1;
      t  = j / 5;
      p  = j % 5;
      eg = (p < 4) ? (8'd1 << (t % 8)) : 8'd0;
      step("rotate", 8'hFF, eg, 3'(t % 8), 16'(t + 1));
      t1  = j / 2;
      eg1 = (j % 2 == 0) ? (8'd1 << (t1 % 8)) : 8'd0;
      checks += 2;
      if (g1 !== eg1) begin
        errors++; $display("FAIL hold1 grant got %h want %h", g1, eg1);
      end
      if (g1_count !== 16'(t1 + 1)) begin
        errors++; $display("FAIL hold1 count got %h want %h", g1_count, 16'(t1 + 1));
      end
    end

    do_reset();
    foreach (tab_c[i]) step("drop_wrap", tab_c[i].req, tab_c[i].grant, tab_c[i].id, tab_c[i].count);

    // Asynchronous reset pulse in the middle of a client-4 tenure.
    do_reset();
    step("pre_async", 8'h10, 8'h10, 3'd4, 16'd1);
    step("pre_async", 8'h10, 8'h10, 3'd4, 16'd1);
    #2 reset_n = 1'b0;
    #1 check_out("async_rst", 8'h00, 3'd0, 16'd0);
    #1 reset_n = 1'b1;
    step("post_async", 8'h11, 8'h01, 3'd0, 16'd1);
    step("post_async", 8'h11, 8'h01, 3'd0, 16'd1);

    // The tenure counter saturates at 16'hFFFF.
    do_reset();
    force dut.grant_count_reg = 16'hFFFF;
    #1 release dut.grant_count_reg;
    #1 check_out("forced", 8'h00, 3'd0, 16'hFFFF);
    step("saturate", 8'h02, 8'h02, 3'd1, 16'hFFFF);
    step("saturate", 8'h02, 8'h02, 3'd1, 16'hFFFF);
    step("saturate", 8'h00, 8'h00, 3'd1, 16'hFFFF);
    step("saturate", 8'h02, 8'h02, 3'd1, 16'hFFFF);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
